sdram_rd_arbiter: RTL and testbench

Parametrised N-channel SDRAM read arbiter for the NeoGeo core, sitting between the video/CPU fetch sources (C ROM, S ROM, P ROM/system ROM, and others) and the single 16-bit `sdram` controller. Each channel raises a request level. The arbiter edge-detects the request, queues it, grants channels by fixed or round-robin priority, and issues a per-channel multi-word read burst. The result is stored in a per-channel data latch. A loader port (hps_io download) takes over the memory port for writes when the arbiter is idle.

---
 rtl/sdram_rd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sdram_rd_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_arbiter.sv
// N-channel SDRAM read arbiter: edge-queued requests, fixed or round-robin
// grant, per-channel multi-word bursts, loader pass-through when idle.
module sdram_rd_arbiter #(
    parameter int  CHANNELS  = 4,
    parameter int  AW        = 25,
    parameter int  DW        = 16,
    parameter int  MAX_WORDS = 2,
    localparam int WW        = $clog2(MAX_WORDS) + 1,
    localparam int GW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             rr_mode,
    input  logic [CHANNELS-1:0]              ch_req,
    input  logic [CHANNELS*AW-1:0]           ch_addr,
    input  logic [CHANNELS*WW-1:0]           ch_words,
    output logic [CHANNELS*MAX_WORDS*DW-1:0] ch_data,
    output logic [CHANNELS-1:0]              ch_valid,
    output logic [CHANNELS-1:0]              ch_busy,
    output logic [CHANNELS-1:0]              ch_overrun,
    input  logic                             load,
    input  logic [AW-1:0]                    load_addr,
    input  logic [DW-1:0]                    load_din,
    input  logic                             load_wr,
    output logic                             load_wait,
    output logic [AW-1:0]                    mem_addr,
    output logic [DW-1:0]                    mem_din,
    output logic                             mem_rd,
    output logic                             mem_we,
    input  logic [DW-1:0]                    mem_dout,
    input  logic                             mem_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                          state_q;
    logic [CHANNELS-1:0]             prev_q;
    logic [CHANNELS-1:0]             pending_q;
    logic [CHANNELS-1:0]             pending_d;
    logic [CHANNELS-1:0]             valid_q;
    logic [CHANNELS-1:0]             ovr_q;
    logic [GW-1:0]                   grant_q;
    logic [GW-1:0]                   last_grant_q;
    logic [WW-1:0]                   idx_q;
    logic [CHANNELS*MAX_WORDS*DW-1:0] data_q;

    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] clr;
    logic [AW-1:0]       addr_sel;
    logic [AW-1:0]       cur_addr;
    logic [WW-1:0]       words_sel;
    logic [WW-1:0]       words_eff;
    logic                last_word;
    logic                done;
    logic [GW-1:0]       nxt_grant;
    logic [GW-1:0]       cand_g;
    logic                found;
    int                  cand;

    assign rise      = ch_req & ~prev_q;
    assign addr_sel  = ch_addr[int'(grant_q)*AW +: AW];
    assign words_sel = ch_words[int'(grant_q)*WW +: WW];
    assign cur_addr  = addr_sel + AW'({idx_q, 1'b0});

    always_comb begin
        if (words_sel == '0)
            words_eff = WW'(1);
        else if (words_sel > WW'(MAX_WORDS))
            words_eff = WW'(MAX_WORDS);
        else
            words_eff = words_sel;
    end

    assign last_word = idx_q >= (words_eff - WW'(1));
    assign done      = (state_q == WAIT) && mem_ready && last_word;
    assign clr       = done ? (CHANNELS'(1) << grant_q) : '0;
    assign pending_d = (pending_q | (rise & ~pending_q & {CHANNELS{~load}})) & ~clr;

    // Round-robin search starts just after the last served channel.
    always_comb begin
        nxt_grant = '0;
        found     = 1'b0;
        cand      = 0;
        cand_g    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand   = rr_mode ? (int'(last_grant_q) + 1 + k) % CHANNELS : k;
            cand_g = GW'(cand);
            if (!found && pending_q[cand_g]) begin
                nxt_grant = cand_g;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            valid_q      <= '0;
            ovr_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= GW'(CHANNELS - 1);
            idx_q        <= '0;
            data_q       <= '0;
        end else begin
            prev_q    <= ch_req;
            pending_q <= pending_d;
            valid_q   <= '0;
            ovr_q     <= rise & pending_q & {CHANNELS{~load}};
            case (state_q)
                IDLE: begin
                    if (!load && |pending_q) begin
                        grant_q <= nxt_grant;
                        idx_q   <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (mem_ready) begin
                        data_q[(int'(grant_q)*MAX_WORDS + int'(idx_q))*DW +: DW] <= mem_dout;
                        if (last_word) begin
                            valid_q[grant_q] <= 1'b1;
                            last_grant_q     <= grant_q;
                            state_q          <= IDLE;
                        end else begin
                            idx_q   <= idx_q + WW'(1);
                            state_q <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_rd   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    mem_addr = load_addr;
                    mem_din  = load_din;
                    mem_we   = load_wr;
                end
            end
            ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = cur_addr;
            end
            WAIT:    mem_addr = cur_addr;
            default: mem_addr = '0;
        endcase
    end

    assign load_wait  = load && (state_q != IDLE);
    assign ch_data    = data_q;
    assign ch_valid   = valid_q;
    assign ch_busy    = pending_q;
    assign ch_overrun = ovr_q;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter with a latency-programmable SDRAM
// read model; table-driven single-channel bursts plus multi-cycle sequences.
module tb_sdram_rd_arbiter;

    localparam int CH = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int MW = 2;
    localparam int WW = 2;

    logic                  clk_sys = 1'b0;
    logic                  reset;
    logic                  rr_mode;
    logic [CH-1:0]         ch_req;
    logic [CH*AW-1:0]      ch_addr;
    logic [CH*WW-1:0]      ch_words;
    logic [CH*MW*DW-1:0]   ch_data;
    logic [CH-1:0]         ch_valid;
    logic [CH-1:0]         ch_busy;
    logic [CH-1:0]         ch_overrun;
    logic                  load;
    logic [AW-1:0]         load_addr;
    logic [DW-1:0]         load_din;
    logic                  load_wr;
    logic                  load_wait;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_din;
    logic                  mem_rd;
    logic                  mem_we;
    logic [DW-1:0]         mem_dout;
    logic                  mem_ready;

    logic                  mdl_ready, man_ready;
    logic [DW-1:0]         mdl_dout, man_dout;
    logic                  mdl_en;
    int                    mem_lat;
    int                    nrd;
    logic [AW-1:0]         addr_q[$];

    int checks = 0;
    int errors = 0;

    assign mem_ready = mdl_ready | man_ready;
    assign mem_dout  = mdl_dout | man_dout;

    always #5 clk_sys = ~clk_sys;

    sdram_rd_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .rr_mode(rr_mode),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_words(ch_words),
        .ch_data(ch_data), .ch_valid(ch_valid), .ch_busy(ch_busy),
        .ch_overrun(ch_overrun), .load(load), .load_addr(load_addr),
        .load_din(load_din), .load_wr(load_wr), .load_wait(load_wait),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_dout(mem_dout), .mem_ready(mem_ready)
    );

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 25'h0400000) return 16'hAAAA;
        if (a == 25'h0400002) return 16'h5555;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] wd(input int c, input int k);
        return ch_data[(c*MW+k)*DW +: DW];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] a,
                          input logic [WW-1:0] w);
        ch_addr[c*AW +: AW]  = a;
        ch_words[c*WW +: WW] = w;
    endtask

    // SDRAM model: address taken in the first WAIT cycle, data after mem_lat
    initial begin
        logic [AW-1:0] a;
        mdl_ready = 1'b0;
        mdl_dout  = '0;
        @(posedge clk_sys);
        #1;
        forever begin
            if (mem_rd && mdl_en) begin
                @(posedge clk_sys);
                #1;
                a = mem_addr;
                addr_q.push_back(a);
                nrd++;
                repeat (mem_lat - 1) begin
                    @(posedge clk_sys);
                    #1;
                end
                mdl_dout  = mem_data(a);
                mdl_ready = 1'b1;
                @(posedge clk_sys);
                #1;
                mdl_ready = 1'b0;
                mdl_dout  = '0;
            end else begin
                @(posedge clk_sys);
                #1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [WW-1:0] words;
        int            nrd;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit got;
        int vcyc;
        int t0, t2;
        int order[$];
        logic [CH-1:0] rais;

        vt[0] = '{0, 25'h0001000, 2'd1, 1, 25'h0001000, 25'h0, 16'h4A5A, 16'h0000, 5};
        vt[1] = '{1, 25'h0002468, 2'd0, 1, 25'h0002468, 25'h0, 16'h7E32, 16'h0000, 5};
        vt[2] = '{2, 25'h1FFFFFE, 2'd2, 2, 25'h1FFFFFE, 25'h0000000, 16'hA5A4, 16'h5A5A, 8};
        vt[3] = '{3, 25'h0ABCDE0, 2'd3, 2, 25'h0ABCDE0, 25'h0ABCDE2, 16'h97BA, 16'h97B8, 8};
        vt[4] = '{0, 25'h0000010, 2'd2, 2, 25'h0000010, 25'h0000012, 16'h5A4A, 16'h5A48, 8};
        vt[5] = '{0, 25'h0000100, 2'd1, 1, 25'h0000100, 25'h0, 16'h5B5A, 16'h5A48, 5};

        reset = 1'b1; rr_mode = 1'b0; ch_req = '0; ch_addr = '0;
        ch_words = {CH{2'd1}}; load = 1'b0; load_addr = '0; load_din = '0;
        load_wr = 1'b0; man_ready = 1'b0; man_dout = '0; mdl_en = 1'b1;
        mem_lat = 2; nrd = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", ch_valid, 0);
        chk("rst_busy", ch_busy, 0);
        chk("rst_ovr", ch_overrun, 0);
        chk("rst_data", |ch_data, 0);
        chk("rst_rd_we", {mem_rd, mem_we, load_wait}, 0);
        chk("rst_addr", mem_addr, 0);

        for (int v = 0; v < 6; v++) begin
            set_ch(vt[v].ch, vt[v].addr, vt[v].words);
            addr_q.delete();
            nrd = 0;
            ch_req[vt[v].ch] = 1'b1;
            got = 0;
            vcyc = 0;
            for (int i = 1; i <= 60 && !got; i++) begin
                tick();
                if (ch_valid[vt[v].ch]) begin
                    got = 1;
                    vcyc = i;
                end
            end
            chk($sformatf("v%0d_valid", v), got, 1);
            chk($sformatf("v%0d_lat", v), vcyc, vt[v].lat);
            chk($sformatf("v%0d_nrd", v), nrd, vt[v].nrd);
            chk($sformatf("v%0d_a0", v), addr_q.size() > 0 ? addr_q[0] : 'x, vt[v].a0);
            if (vt[v].nrd == 2)
                chk($sformatf("v%0d_a1", v), addr_q.size() > 1 ? addr_q[1] : 'x, vt[v].a1);
            chk($sformatf("v%0d_d0", v), wd(vt[v].ch, 0), vt[v].d0);
            chk($sformatf("v%0d_d1", v), wd(vt[v].ch, 1), vt[v].d1);
            ch_req[vt[v].ch] = 1'b0;
            tick();
            chk($sformatf("v%0d_idle", v), ch_busy, 0);
        end

        // fixed priority, ch0 and ch2 together
        mem_lat = 4;
        set_ch(0, 25'h0000020, 2'd1);
        set_ch(2, 25'h0000040, 2'd1);
        ch_req[0] = 1'b1; ch_req[2] = 1'b1;
        t0 = -1; t2 = -1; order.delete();
        for (int i = 1; i <= 80 && order.size() < 2; i++) begin
            tick();
            if (ch_valid[0]) begin order.push_back(0); t0 = i; end
            if (ch_valid[2]) begin order.push_back(2); t2 = i; end
        end
        chk("prio_first", order.size() > 0 ? order[0] : -1, 0);
        chk("prio_second", order.size() > 1 ? order[1] : -1, 2);
        chk("prio_lat0", t0, 7);
        chk("prio_gap", t2 - t0, 6);
        ch_req = '0;
        tick();

        // two-word burst
        mem_lat = 2;
        set_ch(0, 25'h0400000, 2'd2);
        addr_q.delete(); nrd = 0;
        ch_req[0] = 1'b1;
        got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (ch_valid[0]) got = 1;
        end
        chk("w2_valid", got, 1);
        chk("w2_a0", addr_q.size() > 0 ? addr_q[0] : 'x, 25'h0400000);
        chk("w2_a1", addr_q.size() > 1 ? addr_q[1] : 'x, 25'h0400002);
        chk("w2_d0", wd(0, 0), 16'hAAAA);
        chk("w2_d1", wd(0, 1), 16'h5555);
        ch_req = '0;
        tick();

        // overrun during WAIT
        mem_lat = 4;
        set_ch(1, 25'h0000300, 2'd1);
        begin
            int nv, no;
            nv = 0; no = 0;
            ch_req[1] = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (i == 3) ch_req[1] = 1'b0;
                if (i == 4) ch_req[1] = 1'b1;
                if (ch_valid[1]) nv++;
                if (ch_overrun[1]) no++;
            end
            chk("ovr_pulses", no, 1);
            chk("ovr_valids", nv, 1);
            chk("ovr_busy", ch_busy, 0);
        end
        ch_req = '0;
        tick();

        // round-robin from reset: 0,1,0,1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_mode = 1'b1;
        mem_lat = 2;
        set_ch(0, 25'h0000500, 2'd1);
        set_ch(1, 25'h0000600, 2'd1);
        order.delete();
        rais = '0;
        ch_req[0] = 1'b1; ch_req[1] = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            ch_req = ch_req | rais;
            rais = '0;
            for (int c = 0; c < 2; c++) begin
                if (ch_valid[c]) begin
                    order.push_back(c);
                    ch_req[c] = 1'b0;
                    if (order.size() < 3) rais[c] = 1'b1;
                end
            end
            if (order.size() >= 4 && ch_busy == '0) break;
        end
        chk("rr_count", order.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("rr_seq%0d", j), order.size() > j ? order[j] : -1, j % 2);
        ch_req = '0;
        tick();

        // after ch1 served, ch2 outranks ch0
        set_ch(2, 25'h0000700, 2'd1);
        order.delete();
        ch_req[0] = 1'b1; ch_req[2] = 1'b1;
        for (int i = 1; i <= 60 && order.size() < 2; i++) begin
            tick();
            if (ch_valid[0]) order.push_back(0);
            if (ch_valid[2]) order.push_back(2);
        end
        chk("rr2_first", order.size() > 0 ? order[0] : -1, 2);
        chk("rr2_second", order.size() > 1 ? order[1] : -1, 0);
        ch_req = '0;
        rr_mode = 1'b0;
        tick();

        // loader arrives mid-burst
        mem_lat = 4;
        set_ch(0, 25'h0000800, 2'd1);
        set_ch(3, 25'h0000200, 2'd1);
        ch_req[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (mem_rd) got = 1;
        end
        chk("ld_rd_seen", got, 1);
        ch_req[3] = 1'b1;
        tick();
        load = 1'b1; load_wr = 1'b1;
        load_addr = 25'h0155AA0; load_din = 16'hBEEF;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ch_valid[0]) got = 1;
            else chk("ld_wait_hi", {load_wait, mem_we}, 2'b10);
        end
        chk("ld_valid0", got, 1);
        chk("ld_wait_lo", load_wait, 0);
        chk("ld_we", mem_we, 1);
        chk("ld_addr", mem_addr, 25'h0155AA0);
        chk("ld_din", mem_din, 16'hBEEF);
        ch_req[0] = 1'b0;
        ch_req[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ld_hold", {mem_rd, ch_busy[3], ch_overrun[2]}, 3'b010);
        end
        ch_req[2] = 1'b0;
        tick();
        load = 1'b0; load_wr = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (ch_valid[3]) got = 1;
        end
        chk("ld_valid3", got, 1);
        chk("ld_d3", wd(3, 0), 16'h585A);
        chk("ld_busy2", ch_busy[2], 0);
        ch_req = '0;
        tick();

        // reset during WAIT, late mem_ready ignored
        mdl_en = 1'b0;
        set_ch(1, 25'h0000900, 2'd1);
        ch_req[1] = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (mem_rd) got = 1;
        end
        chk("rm_rd_seen", got, 1);
        tick();
        reset = 1'b1;
        ch_req = '0;
        tick();
        reset = 1'b0;
        chk("rm_valid", ch_valid, 0);
        chk("rm_busy", ch_busy, 0);
        chk("rm_ovr", ch_overrun, 0);
        chk("rm_data", |ch_data, 0);
        chk("rm_ctl", {mem_rd, mem_we, load_wait}, 0);
        chk("rm_addr", mem_addr, 0);
        man_dout = 16'h1357;
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        man_dout = '0;
        begin
            int nv;
            nv = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (ch_valid != '0) nv++;
            end
            chk("rm_late_valid", nv, 0);
        end
        chk("rm_late_data", |ch_data, 0);
        chk("rm_late_busy", ch_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
